uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
- Sequences the byte stream from the UART receiver into framed command packets: SYNC, CMD, LEN, LEN payload bytes, CHK.
- Writes payload bytes into an external byte buffer (dual-port RAM or register file).
- Reports per-frame status to the command decoder.
- Sits between uart_receiver and the command/execution logic; runs on the system clock, not the sub-baud tick.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
MAX_LEN, 16, largest accepted payload length (1..2^ADDR_W)
ADDR_W, 4, payload buffer address width
TIMEOUT_CYCLES, 500000, max clk cycles allowed between bytes inside a frame

Ports:
clk  in  1  system clock
nrst  in  1  synchronous active-low reset
rx_data  in  8  byte from the receiver, stable while rx_ready is high
rx_ready  in  1  receiver data-ready level; may stay high for many clk cycles per byte
buf_we  out  1  payload buffer write strobe
buf_addr  out  ADDR_W  payload byte index, 0-based
buf_wdata  out  8  payload byte
pkt_valid  out  1  one-cycle pulse: good frame received
pkt_cmd  out  8  CMD of the last good frame
pkt_len  out  8  LEN of the last good frame
err_chk  out  1  one-cycle pulse: checksum mismatch
err_len  out  1  one-cycle pulse: LEN > MAX_LEN
err_timeout  out  1  one-cycle pulse: inter-byte timeout
busy  out  1  high in any state other than HUNT

Behaviour:
- Reset: nrst is synchronous and active-low. All outputs are 0 and the state is HUNT. rx_ready_q resets to 1, so a high rx_ready at reset release produces no strobe. The timeout counter and running checksum reset to 0.
- Byte strobe: rx_stb = rx_ready & ~rx_ready_q, with rx_ready_q registered every clk. Exactly one strobe per byte, however long rx_ready stays high. rx_data is sampled in the strobe cycle.
- Running checksum: 8-bit XOR of CMD, LEN and all payload bytes. The checksum is cleared on entry to CMD.
- States (transitions occur on rx_stb unless noted):
  - HUNT: byte == SYNC_BYTE -> CMD. Any other byte is discarded silently.
  - CMD: latch cmd_r, chk = byte -> LEN.
  - LEN:
    - byte > MAX_LEN -> err_len pulse, HUNT.
    - byte == 0 -> CHK.
    - otherwise latch len_r, cnt = 0, chk ^= byte -> PAYLOAD.
  - PAYLOAD:
    - On each byte: buf_we = 1, buf_addr = cnt, buf_wdata = byte, chk ^= byte, cnt++.
    - When cnt reaches len_r - 1 on a strobe -> CHK.
  - CHK:
    - byte == chk -> pkt_valid pulse; pkt_cmd and pkt_len update in that same cycle.
    - byte != chk -> err_chk pulse.
    - Either way -> HUNT.
- Latency: buf_*, pkt_valid and err_* are registered and assert on the clk after the strobe cycle, for exactly one cycle.
- pkt_cmd and pkt_len hold their values until the next good frame; error frames do not change them. Buffer contents after an error frame are undefined.
- Timeout:
  - Counter clears on every rx_stb and in HUNT, and increments otherwise.
  - Reaching TIMEOUT_CYCLES-1 while not in HUNT -> err_timeout pulse, HUNT.
  - A strobe in the same cycle as expiry wins: the byte is processed and the counter clears.
- SYNC_BYTE inside CMD/LEN/PAYLOAD/CHK is treated as data; there is no resync mid-frame.
- A byte arriving in the same cycle as an error pulse is already in HUNT and is evaluated as a possible SYNC.
- nrst low mid-frame aborts the frame with no error pulse; everything returns to reset values.
- Widths: cnt is ADDR_W+1 bits, so MAX_LEN = 2^ADDR_W does not wrap. buf_addr = cnt[ADDR_W-1:0].

Test Plan:
- Good frame A5 10 03 11 22 33 C1 (chk = 10^03^11^22^33 = 0x13; send 0x13, not C1) -> exactly 3 buf_we at addr 0,1,2 with data 11,22,33; one pkt_valid, pkt_cmd=10, pkt_len=3; no error pulses.
- Same frame with CHK=0x00 -> 3 writes, err_chk for 1 cycle, no pkt_valid, pkt_cmd/pkt_len keep their previous values.
- rx_ready held high for 200 clk per byte; frame A5 07 00 07 -> LEN=0 goes straight to CHK, zero buf_we, one pkt_valid with pkt_len=0, no duplicate strobes.
- A5 01 11 (LEN=17 > MAX_LEN), then A5 02 01 55 56 -> err_len after the third byte; second frame accepted with buf_we at addr 0 data 55 and pkt_valid.
- Garbage 00 FF 5A, then A5 01 02 then silence for TIMEOUT_CYCLES -> garbage ignored, busy high after A5, err_timeout exactly once, busy low afterwards; a following good frame is accepted.
- nrst pulsed low mid-PAYLOAD with rx_ready high at release -> all outputs 0, busy 0, no spurious strobe; the next full frame is accepted normally.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// Frames the receiver byte stream (SYNC, CMD, LEN, payload, CHK) into command packets,
// writing payload bytes to an external buffer and pulsing per-frame status.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         ADDR_W         = 4,
    parameter int         TIMEOUT_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_wdata,
    output logic              pkt_valid,
    output logic [7:0]        pkt_cmd,
    output logic [7:0]        pkt_len,
    output logic              err_chk,
    output logic              err_len,
    output logic              err_timeout,
    output logic              busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {HUNT, CMD, LEN, PAYLOAD, CHK} state_t;

    state_t            state, state_n;
    logic              rx_ready_q;
    logic              rx_stb;
    logic [7:0]        cmd_r, cmd_n;
    logic [7:0]        len_r, len_n;
    logic [ADDR_W:0]   cnt, cnt_n;
    logic [7:0]        chk, chk_n;
    logic [TW-1:0]     tmo, tmo_n;
    logic              we_n, pv_n, ec_n, el_n, et_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        wdata_n, pcmd_n, plen_n;

    assign rx_stb = rx_ready & ~rx_ready_q;
    assign busy   = (state != HUNT);

    always_comb begin
        state_n = state;
        cmd_n   = cmd_r;
        len_n   = len_r;
        cnt_n   = cnt;
        chk_n   = chk;
        we_n    = 1'b0;
        addr_n  = buf_addr;
        wdata_n = buf_wdata;
        pv_n    = 1'b0;
        pcmd_n  = pkt_cmd;
        plen_n  = pkt_len;
        ec_n    = 1'b0;
        el_n    = 1'b0;
        et_n    = 1'b0;
        tmo_n   = (rx_stb || state == HUNT) ? '0 : tmo + 1'b1;

        if (rx_stb) begin
            case (state)
                HUNT: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_n = CMD;
                        chk_n   = 8'h00;
                    end
                end
                CMD: begin
                    cmd_n   = rx_data;
                    chk_n   = rx_data;
                    state_n = LEN;
                end
                LEN: begin
                    // LEN=0 is latched too so a zero-length packet reports pkt_len=0
                    len_n = rx_data;
                    cnt_n = '0;
                    if (int'(rx_data) > MAX_LEN) begin
                        el_n    = 1'b1;
                        state_n = HUNT;
                    end else if (rx_data == 8'h00) begin
                        state_n = CHK;
                    end else begin
                        chk_n   = chk ^ rx_data;
                        state_n = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    we_n    = 1'b1;
                    addr_n  = cnt[ADDR_W-1:0];
                    wdata_n = rx_data;
                    chk_n   = chk ^ rx_data;
                    cnt_n   = cnt + 1'b1;
                    if (int'(cnt) == int'(len_r) - 1)
                        state_n = CHK;
                end
                CHK: begin
                    if (rx_data == chk) begin
                        pv_n   = 1'b1;
                        pcmd_n = cmd_r;
                        plen_n = len_r;
                    end else begin
                        ec_n = 1'b1;
                    end
                    state_n = HUNT;
                end
                default: state_n = HUNT;
            endcase
        end else if (state != HUNT && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            et_n    = 1'b1;
            state_n = HUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state       <= HUNT;
            rx_ready_q  <= 1'b1;
            cmd_r       <= '0;
            len_r       <= '0;
            cnt         <= '0;
            chk         <= '0;
            tmo         <= '0;
            buf_we      <= 1'b0;
            buf_addr    <= '0;
            buf_wdata   <= '0;
            pkt_valid   <= 1'b0;
            pkt_cmd     <= '0;
            pkt_len     <= '0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            rx_ready_q  <= rx_ready;
            cmd_r       <= cmd_n;
            len_r       <= len_n;
            cnt         <= cnt_n;
            chk         <= chk_n;
            tmo         <= tmo_n;
            buf_we      <= we_n;
            buf_addr    <= addr_n;
            buf_wdata   <= wdata_n;
            pkt_valid   <= pv_n;
            pkt_cmd     <= pcmd_n;
            pkt_len     <= plen_n;
            err_chk     <= ec_n;
            err_len     <= el_n;
            err_timeout <= et_n;
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Byte-level directed vectors for uart_rx_frame_ctrl plus hand sequences for
// timeout and mid-frame reset.
module tb_uart_rx_frame_ctrl;
    localparam int T = 1000;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       buf_we, pkt_valid, err_chk, err_len, err_timeout, busy;
    logic [3:0] buf_addr;
    logic [7:0] buf_wdata, pkt_cmd, pkt_len;

    uart_rx_frame_ctrl #(
        .SYNC_BYTE(8'hA5), .MAX_LEN(16), .ADDR_W(4), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .nrst(nrst), .rx_data(rx_data), .rx_ready(rx_ready),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .pkt_valid(pkt_valid), .pkt_cmd(pkt_cmd), .pkt_len(pkt_len),
        .err_chk(err_chk), .err_len(err_len), .err_timeout(err_timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         hold;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wd;
        logic       pv, ec, el, busy;
        logic [7:0] pcmd, plen;
    } vec_t;

    vec_t vt[$];
    int   n_vec = 0, n_bad = 0;
    int   c_we = 0, c_pv = 0, c_ec = 0, c_el = 0, c_et = 0;

    // Pulse counters sample pre-edge values, so every asserted cycle is seen once.
    always @(posedge clk) begin
        if (buf_we)      c_we++;
        if (pkt_valid)   c_pv++;
        if (err_chk)     c_ec++;
        if (err_len)     c_el++;
        if (err_timeout) c_et++;
    end

    function automatic vec_t mk(input logic [7:0] b, input int hold, input logic we,
                                input logic [3:0] addr, input logic [7:0] wd,
                                input logic pv, input logic ec, input logic el,
                                input logic bz, input logic [7:0] pcmd, input logic [7:0] plen);
        vec_t v;
        v.b = b; v.hold = hold; v.we = we; v.addr = addr; v.wd = wd;
        v.pv = pv; v.ec = ec; v.el = el; v.busy = bz; v.pcmd = pcmd; v.plen = plen;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic apply(input int i);
        vec_t        v;
        logic [33:0] got, exp;
        v = vt[i];
        @(negedge clk);
        rx_data  = v.b;
        rx_ready = 1'b1;
        @(negedge clk);
        got = {buf_we, buf_we ? buf_addr : 4'h0, buf_we ? buf_wdata : 8'h00,
               pkt_valid, err_chk, err_len, err_timeout, busy, pkt_cmd, pkt_len};
        exp = {v.we, v.we ? v.addr : 4'h0, v.we ? v.wd : 8'h00,
               v.pv, v.ec, v.el, 1'b0, v.busy, v.pcmd, v.plen};
        check($sformatf("vec%0d byte %h {we,addr,wd,pv,ec,el,et,busy,cmd,len}", i, v.b),
              64'(got), 64'(exp));
        repeat (v.hold - 1) @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) apply(i);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({buf_we, buf_addr, buf_wdata, pkt_valid, pkt_cmd, pkt_len,
                    err_chk, err_len, err_timeout, busy});
    endfunction

    int g[8];
    int s_we, s_pv, s_ec, s_el, s_et;

    initial begin
        // frame 1: good, chk = 10^03^11^22^33 = 13
        g[0] = vt.size();
        vt.push_back(mk(8'hA5, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00));
        vt.push_back(mk(8'h10, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00));
        vt.push_back(mk(8'h03, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00));
        vt.push_back(mk(8'h11, 1, 1, 0, 8'h11, 0, 0, 0, 1, 8'h00, 8'h00));
        vt.push_back(mk(8'h22, 1, 1, 1, 8'h22, 0, 0, 0, 1, 8'h00, 8'h00));
        vt.push_back(mk(8'h33, 1, 1, 2, 8'h33, 0, 0, 0, 1, 8'h00, 8'h00));
        vt.push_back(mk(8'h13, 1, 0, 0, 8'h00, 1, 0, 0, 0, 8'h10, 8'h03));
        // frame 2: same with bad checksum
        g[1] = vt.size();
        vt.push_back(mk(8'hA5, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h10, 8'h03));
        vt.push_back(mk(8'h10, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h10, 8'h03));
        vt.push_back(mk(8'h03, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h10, 8'h03));
        vt.push_back(mk(8'h11, 1, 1, 0, 8'h11, 0, 0, 0, 1, 8'h10, 8'h03));
        vt.push_back(mk(8'h22, 1, 1, 1, 8'h22, 0, 0, 0, 1, 8'h10, 8'h03));
        vt.push_back(mk(8'h33, 1, 1, 2, 8'h33, 0, 0, 0, 1, 8'h10, 8'h03));
        vt.push_back(mk(8'h00, 1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h10, 8'h03));
        // frame 3: long rx_ready, LEN=0
        g[2] = vt.size();
        vt.push_back(mk(8'hA5, 200, 0, 0, 8'h00, 0, 0, 0, 1, 8'h10, 8'h03));
        vt.push_back(mk(8'h07, 200, 0, 0, 8'h00, 0, 0, 0, 1, 8'h10, 8'h03));
        vt.push_back(mk(8'h00, 200, 0, 0, 8'h00, 0, 0, 0, 1, 8'h10, 8'h03));
        vt.push_back(mk(8'h07, 200, 0, 0, 8'h00, 1, 0, 0, 0, 8'h07, 8'h00));
        // frame 4: LEN=17 rejected, then 1-byte frame
        g[3] = vt.size();
        vt.push_back(mk(8'hA5, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h07, 8'h00));
        vt.push_back(mk(8'h01, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h07, 8'h00));
        vt.push_back(mk(8'h11, 1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h07, 8'h00));
        vt.push_back(mk(8'hA5, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h07, 8'h00));
        vt.push_back(mk(8'h02, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h07, 8'h00));
        vt.push_back(mk(8'h01, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h07, 8'h00));
        vt.push_back(mk(8'h55, 1, 1, 0, 8'h55, 0, 0, 0, 1, 8'h07, 8'h00));
        vt.push_back(mk(8'h56, 1, 0, 0, 8'h00, 1, 0, 0, 0, 8'h02, 8'h01));
        // frame 5a: garbage then a frame that stalls in PAYLOAD
        g[4] = vt.size();
        vt.push_back(mk(8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h02, 8'h01));
        vt.push_back(mk(8'hFF, 1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h02, 8'h01));
        vt.push_back(mk(8'h5A, 1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h02, 8'h01));
        vt.push_back(mk(8'hA5, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h02, 8'h01));
        vt.push_back(mk(8'h01, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h02, 8'h01));
        vt.push_back(mk(8'h02, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h02, 8'h01));
        // frame 5b: good frame after timeout, chk = 03^01^44 = 46
        g[5] = vt.size();
        vt.push_back(mk(8'hA5, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h02, 8'h01));
        vt.push_back(mk(8'h03, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h02, 8'h01));
        vt.push_back(mk(8'h01, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h02, 8'h01));
        vt.push_back(mk(8'h44, 1, 1, 0, 8'h44, 0, 0, 0, 1, 8'h02, 8'h01));
        vt.push_back(mk(8'h46, 1, 0, 0, 8'h00, 1, 0, 0, 0, 8'h03, 8'h01));
        // frame 6a: partial frame interrupted by reset
        g[6] = vt.size();
        vt.push_back(mk(8'hA5, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h03, 8'h01));
        vt.push_back(mk(8'h20, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h03, 8'h01));
        vt.push_back(mk(8'h02, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h03, 8'h01));
        vt.push_back(mk(8'hAA, 1, 1, 0, 8'hAA, 0, 0, 0, 1, 8'h03, 8'h01));
        // frame 6b: after reset, chk = 21^02^BB^CC = 54
        g[7] = vt.size();
        vt.push_back(mk(8'hA5, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00));
        vt.push_back(mk(8'h21, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00));
        vt.push_back(mk(8'h02, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00));
        vt.push_back(mk(8'hBB, 1, 1, 0, 8'hBB, 0, 0, 0, 1, 8'h00, 8'h00));
        vt.push_back(mk(8'hCC, 1, 1, 1, 8'hCC, 0, 0, 0, 1, 8'h00, 8'h00));
        vt.push_back(mk(8'h54, 1, 0, 0, 8'h00, 1, 0, 0, 0, 8'h21, 8'h02));

        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("reset outputs", all_outs(), 64'h0);

        s_we = c_we; s_pv = c_pv; s_ec = c_ec;
        run(g[0], g[1]);
        check("frame1 write count", 64'(c_we - s_we), 64'd3);
        check("frame1 pkt_valid count", 64'(c_pv - s_pv), 64'd1);
        check("frame1 err_chk count", 64'(c_ec - s_ec), 64'd0);

        s_pv = c_pv; s_ec = c_ec;
        run(g[1], g[2]);
        check("frame2 pkt_valid count", 64'(c_pv - s_pv), 64'd0);
        check("frame2 err_chk count", 64'(c_ec - s_ec), 64'd1);

        s_we = c_we; s_pv = c_pv;
        run(g[2], g[3]);
        check("long-ready write count", 64'(c_we - s_we), 64'd0);
        check("long-ready pkt_valid count", 64'(c_pv - s_pv), 64'd1);

        s_el = c_el; s_pv = c_pv;
        run(g[3], g[4]);
        check("len err count", 64'(c_el - s_el), 64'd1);
        check("len recovery pkt_valid count", 64'(c_pv - s_pv), 64'd1);

        run(g[4], g[5]);
        s_et = c_et;
        repeat (T - 20) @(negedge clk);
        check("busy before timeout", 64'(busy), 64'd1);
        repeat (70) @(negedge clk);
        check("timeout pulse count", 64'(c_et - s_et), 64'd1);
        check("busy after timeout", 64'(busy), 64'd0);
        run(g[5], g[6]);

        run(g[6], g[7]);
        @(negedge clk);
        rx_ready = 1'b1;
        rx_data  = 8'h5C;
        nrst     = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        s_we = c_we;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("post-reset outputs cyc%0d", k), all_outs(), 64'h0);
        end
        rx_ready = 1'b0;
        @(negedge clk);
        check("post-reset spurious writes", 64'(c_we - s_we), 64'd0);
        run(g[7], vt.size());
        repeat (2) @(negedge clk);
        check("total timeouts", 64'(c_et), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
